// File: rtl/ysyx_2022040010_div.sv
// ----------------------------------------------------------------------------
// ysyx_2022040010_div
//
// Iterative RV64 integer divider (DIV/DIVU/REM/REMU and their W variants).
// Radix-2 restoring division on operand magnitudes, producing one quotient
// bit per cycle. The sign fix-up and W-variant sign extension are folded
// into the last iteration. Divide-by-zero and signed overflow are resolved
// at acceptance and skip the iteration entirely.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   div_valid   request present
//   div_ready   unit is idle and can accept a request
//   div_signed  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   div_rem     1 = return remainder, 0 = return quotient
//   div_32      W variant: use low 32 bits, sign-extend the 32-bit result
//   div_src1    dividend
//   div_src2    divisor
//   div_flush   abort the in-flight operation / block acceptance
//   div_result  quotient or remainder, held until the next completion
//   div_over    one-cycle completion pulse
// ----------------------------------------------------------------------------
module ysyx_2022040010_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        div_rem,
    input  logic        div_32,
    input  logic [63:0] div_src1,
    input  logic [63:0] div_src2,
    input  logic        div_flush,
    output logic [63:0] div_result,
    output logic        div_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  cnt;

    // Operation attributes latched at acceptance
    logic        op_rem;
    logic        op_32;
    logic        neg_q;
    logic        neg_r;

    // Iteration datapath: quotient shift register (dividend bits shift out
    // of the top while quotient bits shift in at the bottom) and remainder.
    logic [63:0] quo;
    logic [63:0] rem_acc;
    logic [63:0] divisor_mag;

    // Sign-extend a 32-bit result to 64 bits for W variants.
    function automatic logic [63:0] fix_width(input logic [63:0] v, input logic w32);
        return w32 ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    function automatic logic [63:0] apply_sign(input logic [63:0] v, input logic neg);
        return neg ? (64'd0 - v) : v;
    endfunction

    // ------------------------------------------------------------------
    // Acceptance-side decode
    // ------------------------------------------------------------------
    logic        accept;
    logic [63:0] opa, opb;
    logic        a_neg, b_neg;
    logic [63:0] mag_a, mag_b;
    logic        div_zero, sign_ovf, special;
    logic [63:0] special_res;

    always_comb begin
        accept = (state == IDLE) && div_valid && !div_flush;

        // Operands at operating width, extended to 64 bits
        if (div_32) begin
            opa = div_signed ? {{32{div_src1[31]}}, div_src1[31:0]} : {32'd0, div_src1[31:0]};
            opb = div_signed ? {{32{div_src2[31]}}, div_src2[31:0]} : {32'd0, div_src2[31:0]};
        end else begin
            opa = div_src1;
            opb = div_src2;
        end

        a_neg = div_signed && opa[63];
        b_neg = div_signed && opb[63];
        mag_a = apply_sign(opa, a_neg);
        mag_b = apply_sign(opb, b_neg);

        div_zero = (opb == 64'd0);
        sign_ovf = div_signed && (opb == {64{1'b1}}) &&
                   (opa == (div_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = div_zero || sign_ovf;

        if (div_zero)
            special_res = div_rem ? opa : {64{1'b1}};
        else
            special_res = div_rem ? 64'd0 : opa;
        special_res = fix_width(special_res, div_32);
    end

    // ------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------
    logic [64:0] rem_shift;
    logic        ge;
    logic [63:0] rem_next, quo_next;
    logic [63:0] final_res;

    always_comb begin
        rem_shift = {rem_acc, quo[63]};
        ge        = (rem_shift >= {1'b0, divisor_mag});
        // True difference is below the divisor, so 64 bits hold it exactly.
        rem_next  = ge ? (rem_shift[63:0] - divisor_mag) : rem_shift[63:0];
        quo_next  = {quo[62:0], ge};
        final_res = fix_width(op_rem ? apply_sign(rem_next, neg_r)
                                     : apply_sign(quo_next, neg_q), op_32);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : BUSY;
            end
            BUSY: begin
                if (div_flush)
                    state_nxt = IDLE;
                else if (cnt == 7'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 7'd0;
            div_result <= 64'd0;
            op_rem     <= 1'b0;
            op_32      <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_rem <= div_rem;
                op_32  <= div_32;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                cnt    <= special ? 7'd0 : (div_32 ? 7'd32 : 7'd64);
                if (special)
                    div_result <= special_res;
            end else if (state == BUSY) begin
                if (div_flush) begin
                    cnt <= 7'd0;
                end else begin
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1)
                        div_result <= final_res;
                end
            end
        end
    end

    // Datapath registers need no reset: they are always loaded at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            // W variants park the 32-bit magnitude in the top half so it
            // shifts out first; after 32 steps the quotient fills the low half.
            quo         <= div_32 ? {mag_a[31:0], 32'd0} : mag_a;
            rem_acc     <= 64'd0;
            divisor_mag <= mag_b;
        end else if (state == BUSY) begin
            quo     <= quo_next;
            rem_acc <= rem_next;
        end
    end

    assign div_ready = (state == IDLE);
    assign div_over  = (state == DONE) && !div_flush;

endmodule
